// File: rtl/program_loader.sv
// Byte-stream program loader: takes a little-endian word count followed by
// that many little-endian instruction words and writes them to instruction memory.
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_req,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [31:0] ADDRESS,
  output logic [31:0] INSTRUCTION,
  output logic        instr_we,
  output logic        enable_inst_in,
  output logic        start,
  output logic        busy,
  output logic        err
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_RUN, S_ERR} state_e;

  state_e      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] remain_q, remain_d;
  logic [31:0] address_q, address_d;
  logic [31:0] instr_q, instr_d;
  logic        byte_ready_q, byte_ready_d;
  logic        instr_we_q, instr_we_d;
  logic        enable_q, enable_d;
  logic        start_q, start_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic        xfer;

  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    address_d = address_q;
    instr_d   = instr_q;
    xfer      = byte_valid && (state_q == S_LEN || state_q == S_DATA);
    // Shift right so the first byte of a group ends up in bits 7:0.
    if (xfer) begin
      asm_d  = {byte_data, asm_q[31:8]};
      bcnt_d = bcnt_q + 2'd1;
    end
    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_req) begin
          state_d = S_LEN;
          bcnt_d  = 2'd0;
          addr_d  = BASE_ADDR;
        end
      end
      S_LEN: begin
        if (xfer && bcnt_q == 2'd3) begin
          if (asm_d == 32'd0 || asm_d > MAX_W) begin
            state_d = S_ERR;
          end else begin
            remain_d = asm_d;
            state_d  = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer && bcnt_q == 2'd3) begin
          state_d   = S_WRITE;
          address_d = addr_q;
          instr_d   = asm_d;
        end
      end
      S_WRITE: begin
        addr_d   = addr_q + 32'd4;
        remain_d = remain_q - 32'd1;
        state_d  = (remain_q == 32'd1) ? S_RUN : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet state-aligned.
    byte_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
    busy_d       = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_WRITE);
    enable_d     = busy_d;
    instr_we_d   = (state_d == S_WRITE);
    start_d      = (state_d == S_RUN);
    err_d        = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bcnt_q       <= 2'd0;
      asm_q        <= 32'd0;
      addr_q       <= BASE_ADDR;
      remain_q     <= 32'd0;
      address_q    <= BASE_ADDR;
      instr_q      <= 32'd0;
      byte_ready_q <= 1'b0;
      instr_we_q   <= 1'b0;
      enable_q     <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      asm_q        <= asm_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      address_q    <= address_d;
      instr_q      <= instr_d;
      byte_ready_q <= byte_ready_d;
      instr_we_q   <= instr_we_d;
      enable_q     <= enable_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign byte_ready     = byte_ready_q;
  assign ADDRESS        = address_q;
  assign INSTRUCTION    = instr_q;
  assign instr_we       = instr_we_q;
  assign enable_inst_in = enable_q;
  assign start          = start_q;
  assign busy           = busy_q;
  assign err            = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized and directed loads against a queue-based model of the expected
// write sequence, latency and final run/error outcome.
module tb_program_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_req = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic [31:0] ADDRESS;
  logic [31:0] INSTRUCTION;
  logic        instr_we;
  logic        enable_inst_in;
  logic        start;
  logic        busy;
  logic        err;

  program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .ADDRESS(ADDRESS),
    .INSTRUCTION(INSTRUCTION), .instr_we(instr_we), .enable_inst_in(enable_inst_in),
    .start(start), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          c;
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  wr_t         wr_q[$];
  int          acc_q[$];
  logic [31:0] wq[$];
  logic [31:0] exp_addr = BASE;
  logic [31:0] exp_instr = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed transfers and write strobes, sampled mid-cycle.
  always @(negedge clk) begin
    wr_t w;
    if (byte_valid && byte_ready) acc_q.push_back(cyc);
    if (instr_we) begin
      w.c = cyc; w.a = ADDRESS; w.d = INSTRUCTION;
      wr_q.push_back(w);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    logic r;
    r = 1'b0;
    if (gap) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); r = byte_ready;
      @(posedge clk); #1;
      if (r) break;
    end
    byte_valid = 1'b0;
    if (!r) chk("byte_accept_timeout", {31'd0, r}, 32'd1);
  endtask

  // Full load of header n plus the words in wq (only if n is legal).
  task automatic run_load(input logic [31:0] n, input bit stall);
    int  wbase, abase, nexp;
    bit  bad;
    pulse_load();
    chk("req_busy", {31'd0, busy}, 32'd1);
    chk("req_enable", {31'd0, enable_inst_in}, 32'd1);
    chk("req_start", {31'd0, start}, 32'd0);
    chk("req_err", {31'd0, err}, 32'd0);
    wbase = wr_q.size();
    abase = acc_q.size();
    for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], stall);
    bad  = (n == 32'd0) || (n > 32'(MAXW));
    nexp = bad ? 0 : int'(n);
    for (int k = 0; k < nexp; k++)
      for (int b = 0; b < 4; b++) send_byte(wq[k][8*b +: 8], stall);
    repeat (2) @(posedge clk);
    #1;
    chk("end_err", {31'd0, err}, {31'd0, bad});
    chk("end_start", {31'd0, start}, {31'd0, !bad});
    chk("end_enable", {31'd0, enable_inst_in}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("num_writes", 32'(wr_q.size() - wbase), 32'(nexp));
    for (int k = 0; k < nexp; k++) begin
      if (wbase + k < wr_q.size()) begin
        chk("wr_addr", wr_q[wbase+k].a, BASE + 32'(4*k));
        chk("wr_data", wr_q[wbase+k].d, wq[k]);
        if (abase + 7 + 4*k < acc_q.size())
          chk("wr_latency", 32'(wr_q[wbase+k].c), 32'(acc_q[abase + 7 + 4*k] + 1));
      end
    end
    if (!bad) begin
      exp_addr  = BASE + 32'(4*(nexp-1));
      exp_instr = wq[nexp-1];
    end
    chk("hold_addr", ADDRESS, exp_addr);
    chk("hold_instr", INSTRUCTION, exp_instr);
  endtask

  initial begin
    int nw;
    #12;
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, instr_we}, 32'd0);
    chk("rst_enable", {31'd0, enable_inst_in}, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_addr", ADDRESS, BASE);
    chk("rst_instr", INSTRUCTION, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_no_accept", 32'(acc_q.size()), 32'd0);

    // Two-word program
    wq.delete(); wq.push_back(32'h0010_0513); wq.push_back(32'h0020_0593);
    run_load(32'd2, 1'b0);
    // Zero length, then oversize, then a legal one-word load out of ERR
    wq.delete();
    run_load(32'd0, 1'b0);
    run_load(32'd5, 1'b0);
    wq.delete(); wq.push_back(32'h0000_006F);
    run_load(32'd1, 1'b0);
    // Stalled stream
    wq.delete(); wq.push_back($urandom);
    run_load(32'd1, 1'b1);

    // Reset in the middle of the first data word
    pulse_load();
    send_byte(8'h03, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
    send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
    nw = wr_q.size();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_enable", {31'd0, enable_inst_in}, 32'd0);
    chk("mid_rst_addr", ADDRESS, BASE);
    chk("mid_rst_instr", INSTRUCTION, 32'h0);
    exp_addr = BASE; exp_instr = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_no_write", 32'(wr_q.size()), 32'(nw));
    chk("mid_rst_idle", {31'd0, busy}, 32'd0);
    wq.delete(); wq.push_back($urandom); wq.push_back($urandom); wq.push_back($urandom);
    run_load(32'd3, 1'b0);

    // Randomized programs, including illegal lengths and stalled streams
    for (int t = 0; t < 10; t++) begin
      logic [31:0] n;
      n = 32'($urandom_range(0, MAXW + 2));
      wq.delete();
      for (int k = 0; k < int'(n); k++) wq.push_back($urandom);
      run_load(n, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
